// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the shared data memory: port 0 (pipeline MEM stage) normally wins,
// port 1 (debug/DMA loader) is forced through after STARVE_LIMIT denied cycles. Read data is registered.
module data_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt;
  logic       force_p1;
  logic       rd0_take;
  logic       rd1_take;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [3:0] wait_next(input logic [3:0] v, input logic req, input logic gnt);
    if (gnt || !req)
      return 4'd0;
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  // Arbitration and memory drive: combinational, gated off entirely while reset is low.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    force_p1  = p1_req && (wait_cnt >= STARVE_LIM);
    if (reset) begin
      if (force_p1)
        p1_gnt = 1'b1;
      else if (p0_req)
        p0_gnt = 1'b1;
      else if (p1_req)
        p1_gnt = 1'b1;
    end
    if (p0_gnt) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  assign rd0_take = p0_gnt & ~p0_we;
  assign rd1_take = p1_gnt & ~p1_we;

  // Response stage: read data captured at the edge ending the grant cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      wait_cnt     <= 4'd0;
      conflict_cnt <= 16'd0;
    end else begin
      p0_rvalid <= rd0_take;
      p1_rvalid <= rd1_take;
      if (rd0_take)
        p0_rdata <= mem_rdata;
      if (rd1_take)
        p1_rdata <= mem_rdata;
      wait_cnt <= wait_next(wait_cnt, p1_req, p1_gnt);
      if (p0_req && p1_req)
        conflict_cnt <= sat_inc16(conflict_cnt);
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a behavioural memory on the mem_* bus, a reference
// memory image and per-port queues of expected read data popped when responses are due.
module tb_data_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   conflict_cnt;

  logic [DW-1:0] tmem    [256];
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] exp_rd0, exp_rd1;
  logic [15:0]   exp_conf;
  int            compared   = 0;
  int            mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) tmem[mem_addr] <= mem_wdata;
  assign mem_rdata = tmem[mem_addr];

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic check_rsp();
    if (q0.size() > 0) begin
      exp_rd0 = q0.pop_front();
      check("p0_rvalid", p0_rvalid, 1);
    end else check("p0_rvalid", p0_rvalid, 0);
    check("p0_rdata", p0_rdata, exp_rd0);
    if (q1.size() > 0) begin
      exp_rd1 = q1.pop_front();
      check("p1_rvalid", p1_rvalid, 1);
    end else check("p1_rvalid", p1_rvalid, 0);
    check("p1_rdata", p1_rdata, exp_rd1);
    check("conflict_cnt", conflict_cnt, exp_conf);
  endtask

  task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                      input logic eg0, input logic eg1);
    logic       ewe;
    logic [7:0] ea, ed;
    @(negedge clk);
    check_rsp();
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #1;
    check("p0_gnt", p0_gnt, eg0);
    check("p1_gnt", p1_gnt, eg1);
    ewe = 1'b0; ea = 8'h00; ed = 8'h00;
    if (eg0) begin ewe = w0; ea = a0; ed = d0; end
    else if (eg1) begin ewe = w1; ea = a1; ed = d1; end
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ed);
    if (eg0) begin
      if (w0) exp_mem[a0] = d0; else q0.push_back(exp_mem[a0]);
    end
    if (eg1) begin
      if (w1) exp_mem[a1] = d1; else q1.push_back(exp_mem[a1]);
    end
    if (r0 && r1 && exp_conf != 16'hFFFF) exp_conf++;
  endtask

  initial begin
    exp_rd0 = 8'h00; exp_rd1 = 8'h00; exp_conf = 16'd0;
    reset = 1'b0;
    drive(1, 1, 8'h10, 8'h77, 1, 0, 8'h20, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_conflict", conflict_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    step(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1);
    // p0 write then read of the same address on consecutive cycles
    step(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 1, 0);
    step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    // Continuous contention: p1 forced through on the 5th cycle
    for (int i = 0; i < 6; i++)
      step(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, i != 4, i == 4);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    // p1 alone
    step(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'h01, 0, 1);
    step(0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 1);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

    // Contention builds wait_cnt to 3, then reset lands mid-cycle after a p0 read grant
    for (int i = 0; i < 4; i++)
      step(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    q0.delete(); q1.delete();
    exp_rd0 = 8'h00; exp_rd1 = 8'h00; exp_conf = 16'd0;
    check("amid_p0_gnt", p0_gnt, 0);
    check("amid_p1_gnt", p1_gnt, 0);
    check("amid_mem_we", mem_we, 0);
    check("amid_mem_addr", mem_addr, 0);
    check("amid_p0_rvalid", p0_rvalid, 0);
    check("amid_p0_rdata", p0_rdata, 0);
    check("amid_p1_rdata", p1_rdata, 0);
    check("amid_conflict", conflict_cnt, 0);
    drive(1, 1, 8'h10, 8'hEE, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    check("inrst_p0_rvalid", p0_rvalid, 0);
    check("inrst_mem_we", mem_we, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    // wait_cnt must restart from 0; addr 10 must still hold A5
    for (int i = 0; i < 6; i++)
      step(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, i != 4, i == 4);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);

    // Long contention run to reach conflict_cnt saturation
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      if (i == 30000) check("conflict_mid", conflict_cnt, exp_conf);
      drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
      if (exp_conf != 16'hFFFF) exp_conf++;
    end
    @(negedge clk);
    check("conflict_sat", conflict_cnt, 16'hFFFF);
    check("conflict_model", conflict_cnt, exp_conf);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("conflict_hold", conflict_cnt, 16'hFFFF);
    check("p0_rdata_after_run", p0_rdata, exp_mem[8'h10]);
    check("p1_rdata_after_run", p1_rdata, exp_mem[8'h20]);
    check("p0_rvalid_idle", p0_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
